branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 105 ++++++++++
 tb/tb_branch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: registered branch decision with a circular return-address stack.
// Define BRANCH_STATS_EN to add the 16-bit taken-branch counter on taken_count.
module branch_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [2:0]                   jump_operator,
  input  logic [DATA_W-1:0]            test_value,
  input  logic [ADDR_W-1:0]            dest_address,
  input  logic [ADDR_W-1:0]            return_address,
  input  logic                         err_clr,
  output logic                         pc_write_enabled,
  output logic [ADDR_W-1:0]            pc_target,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic [15:0]                  taken_count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [2:0] OP_JMP  = 3'd0;
  localparam logic [2:0] OP_JEZ  = 3'd1;
  localparam logic [2:0] OP_JNZ  = 3'd2;
  localparam logic [2:0] OP_JGZ  = 3'd3;
  localparam logic [2:0] OP_JLZ  = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [PW:0] C_ONE = 1;
  localparam logic [PW:0] C_FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              pc_we_q, pc_we_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              zero, neg, empty, full, is_call, is_ret, cond, taken;

  always_comb begin
    zero        = test_value == '0;
    neg         = test_value[DATA_W-1];
    empty       = cnt_q == '0;
    full        = cnt_q == C_FULL;
    is_call     = valid_in && jump_operator == OP_CALL;
    is_ret      = valid_in && jump_operator == OP_RET;
    cond        = (jump_operator == OP_JMP || jump_operator == OP_CALL) ? 1'b1 :
                  jump_operator == OP_JEZ ? zero :
                  jump_operator == OP_JNZ ? !zero :
                  jump_operator == OP_JGZ ? (!neg && !zero) :
                  jump_operator == OP_JLZ ? neg :
                  jump_operator == OP_RET ? !empty : 1'b0;
    taken       = valid_in && cond;
    pc_we_d     = taken;
    pc_target_d = !taken ? pc_target_q : is_ret ? ras_mem[ptr_q - P_ONE] : dest_address;
    // a full stack keeps pushing: the pointer wraps onto the oldest entry
    ptr_d       = is_call ? ptr_q + P_ONE : (is_ret && !empty) ? ptr_q - P_ONE : ptr_q;
    cnt_d       = (is_call && !full) ? cnt_q + C_ONE : (is_ret && !empty) ? cnt_q - C_ONE : cnt_q;
    ovf_d       = (ovf_q && !err_clr) || (is_call && full);
    unf_d       = (unf_q && !err_clr) || (is_ret && empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_we_q     <= 1'b0;
      pc_target_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      pc_we_q     <= pc_we_d;
      pc_target_q <= pc_target_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (is_call && !rst) ras_mem[ptr_q] <= return_address;
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q, taken_d;
  always_comb taken_d = taken ? taken_q + 16'd1 : taken_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) taken_q <= '0;
    else taken_q <= taken_d;
  end
  assign taken_count = taken_q;
`else
  assign taken_count = '0;
`endif

  assign pc_write_enabled = pc_we_q;
  assign pc_target        = pc_target_q;
  assign ras_count        = cnt_q;
  assign ras_overflow     = ovf_q;
  assign ras_underflow    = unf_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vectors against a queue-based branch/stack model, checked every cycle.
module tb_branch_unit;
  localparam int DEPTH = 8;
  localparam logic [2:0] JMP = 0, JEZ = 1, JNZ = 2, JGZ = 3, JLZ = 4, CALL = 5, RET = 6, RSV = 7;

  logic        clk = 0, rst = 1, valid_in = 0, err_clr = 0;
  logic [2:0]  jump_operator = 0;
  logic [15:0] test_value = 0, dest_address = 0, return_address = 0;
  logic        pc_write_enabled, ras_overflow, ras_underflow;
  logic [15:0] pc_target, taken_count;
  logic [3:0]  ras_count;

  branch_unit #(.DATA_W(16), .ADDR_W(16), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .jump_operator(jump_operator),
    .test_value(test_value), .dest_address(dest_address), .return_address(return_address),
    .err_clr(err_clr), .pc_write_enabled(pc_write_enabled), .pc_target(pc_target),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic        m_we = 0, m_ovf = 0, m_unf = 0;
  logic [15:0] m_tgt = 0, m_taken = 0;
  logic [15:0] m_stk[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model(input logic v, input logic [2:0] op, input logic [15:0] tv, dest, ra, input logic clr);
    logic t, ovf_new, unf_new;
    t = 0; ovf_new = 0; unf_new = 0;
    if (v) begin
      case (op)
        JMP, CALL: t = 1;
        JEZ: t = tv == 0;
        JNZ: t = tv != 0;
        JGZ: t = $signed(tv) > 0;
        JLZ: t = $signed(tv) < 0;
        RET: t = m_stk.size() > 0;
        default: t = 0;
      endcase
    end
    m_we = t;
    if (t) m_tgt = (op == RET) ? m_stk[$] : dest;
    if (v && op == CALL) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        ovf_new = 1;
      end
      m_stk.push_back(ra);
    end
    if (v && op == RET) begin
      if (t) void'(m_stk.pop_back());
      else unf_new = 1;
    end
    m_ovf = (m_ovf && !clr) || ovf_new;
    m_unf = (m_unf && !clr) || unf_new;
    if (t) m_taken++;
  endtask

  task automatic model_reset();
    m_we = 0; m_tgt = 0; m_ovf = 0; m_unf = 0; m_taken = 0;
    m_stk.delete();
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] tv, dest, ra, input logic clr = 0);
    valid_in = v; jump_operator = op; test_value = tv; dest_address = dest; return_address = ra; err_clr = clr;
    @(posedge clk);
    model(v, op, tv, dest, ra, clr);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("we", 32'(pc_write_enabled), 32'(m_we));
      chk("target", 32'(pc_target), 32'(m_tgt));
      chk("count", 32'(ras_count), 32'(m_stk.size()));
      chk("ovf", 32'(ras_overflow), 32'(m_ovf));
      chk("unf", 32'(ras_underflow), 32'(m_unf));
`ifdef BRANCH_STATS_EN
      chk("taken", 32'(taken_count), 32'(m_taken));
`else
      chk("taken", 32'(taken_count), 32'h0);
`endif
    end
  end

  initial begin
    #12;
    chk("rst_we", 32'(pc_write_enabled), 0);
    chk("rst_tgt", 32'(pc_target), 0);
    chk("rst_cnt", 32'(ras_count), 0);
    chk("rst_flags", 32'({ras_overflow, ras_underflow}), 0);
    rst = 0;
    step(0, JMP, 0, 0, 0);
    // sign tests on the MSB only
    step(1, JLZ, 16'h8000, 16'h0040, 0);
    chk("jlz_8000", 32'({pc_write_enabled, pc_target}), 32'h1_0040);
    step(1, JGZ, 16'h0001, 16'h0040, 0);
    chk("jgz_0001", 32'({pc_write_enabled, pc_target}), 32'h1_0040);
    step(1, JGZ, 16'h0000, 16'h0055, 0);
    chk("jgz_0000", 32'({pc_write_enabled, pc_target}), 32'h0_0040);
    step(1, JLZ, 16'h0000, 16'h0055, 0);
    chk("jlz_0000", 32'({pc_write_enabled, pc_target}), 32'h0_0040);
    step(1, JGZ, 16'h8000, 16'h0066, 0);
    chk("jgz_8000", 32'(pc_write_enabled), 0);
    step(1, JEZ, 16'h0000, 16'h0123, 0);
    step(1, JEZ, 16'h0100, 16'h0124, 0);
    step(1, JNZ, 16'h0100, 16'h0125, 0);
    step(1, JNZ, 16'h0000, 16'h0126, 0);
    step(1, JMP, 16'h0000, 16'h0200, 0);
    step(1, RSV, 16'h0000, 16'h0300, 0);
    chk("rsv", 32'({pc_write_enabled, pc_target}), 32'h0_0200);
    step(0, JMP, 0, 16'h0400, 0);
    chk("idle", 32'({pc_write_enabled, pc_target}), 32'h0_0200);
    step(0, JMP, 0, 0, 0);
    // nested call/return
    step(1, CALL, 0, 16'h0100, 16'h0011);
    chk("call1", 32'({ras_count, pc_target}), 32'h1_0100);
    step(1, CALL, 0, 16'h0200, 16'h0022);
    chk("call2", 32'(ras_count), 2);
    step(1, RET, 0, 16'hFFFF, 0);
    chk("ret1", 32'({pc_write_enabled, ras_count, pc_target}), 32'h11_0022);
    step(1, RET, 0, 16'hFFFF, 0);
    chk("ret2", 32'({pc_write_enabled, ras_count, pc_target}), 32'h10_0011);
    // underflow and set-wins-over-clear
    step(1, RET, 0, 16'h0999, 0);
    chk("unf_we", 32'({pc_write_enabled, ras_underflow}), 32'h1);
    step(1, RET, 0, 16'h0999, 0, 1);
    chk("unf_hold", 32'(ras_underflow), 1);
    step(0, JMP, 0, 0, 0, 1);
    chk("unf_clr", 32'(ras_underflow), 0);
    // overflow: nine calls into eight slots
    for (int i = 1; i <= 9; i++) step(1, CALL, 0, 16'h0500, 16'(i));
    chk("ovf", 32'({ras_overflow, ras_count}), 32'h18);
    for (int i = 0; i < 8; i++) begin
      step(1, RET, 0, 0, 0);
      chk("ovf_pop", 32'(pc_target), 32'(9 - i));
    end
    chk("ovf_empty", 32'(ras_count), 0);
    step(0, JMP, 0, 0, 0, 1);
    chk("ovf_clr", 32'(ras_overflow), 0);
    // mixed directed traffic
    for (int i = 0; i < 40; i++)
      step(1, 3'(i * 5 % 8), 16'(i * 16'h1357), 16'(16'h0A00 + i), 16'(16'h0B00 + i), i % 11 == 0);
    // asynchronous reset mid-operation
    step(1, CALL, 0, 16'h0300, 16'h00A1);
    step(1, CALL, 0, 16'h0300, 16'h00A2);
    step(1, CALL, 0, 16'h0300, 16'h00A3);
    #2 rst = 1;
    #1;
    chk("arst_cnt", 32'(ras_count), 0);
    chk("arst_we", 32'(pc_write_enabled), 0);
    chk("arst_tgt", 32'(pc_target), 0);
    model_reset();
    valid_in = 1; jump_operator = JMP; dest_address = 16'h0777;
    @(posedge clk);
    #3 rst = 0;
    step(0, JMP, 0, 0, 0);
    chk("post_rst_we", 32'(pc_write_enabled), 0);
    step(1, RET, 0, 0, 0);
    chk("post_rst_unf", 32'({pc_write_enabled, ras_underflow}), 32'h1);
    step(1, CALL, 0, 16'h0310, 16'h00C1);
    step(1, RET, 0, 0, 0);
    chk("post_rst_ret", 32'(pc_target), 32'h00C1);
`ifdef BRANCH_STATS_EN
    rst = 1; #1; model_reset(); #3 rst = 0;
    for (int i = 0; i < 16'hFFFF; i++) step(1, JMP, 0, 16'h0001, 0);
    chk("stats_ffff", 32'(taken_count), 32'hFFFF);
    step(1, JMP, 0, 16'h0002, 0);
    chk("stats_wrap", 32'(taken_count), 0);
`else
    step(1, JMP, 0, 16'h0002, 0);
    chk("stats_off", 32'(taken_count), 0);
`endif
    step(0, JMP, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
